// File: rtl/status_digit_scheduler.sv
// Once-per-frame binary-to-ASCII conversion of score/lines/level through one shared double-dabble engine.
// Define STATUS_ZERO_BLANK_EN to replace leading zeros with spaces (units digit always shown).
module status_digit_scheduler #(
    parameter int unsigned BIN_WIDTH = 20,
    parameter int unsigned DIGITS    = 6
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               frame_start_i,
    input  logic [BIN_WIDTH-1:0]               score_bin_i,
    input  logic [BIN_WIDTH-1:0]               lines_bin_i,
    input  logic [BIN_WIDTH-1:0]               level_bin_i,
    output logic [2:0][DIGITS-1:0][6:0]        digits_o,
    output logic                               busy_o,
    output logic                               update_done_o
);

    localparam int unsigned SC_W  = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    function automatic longint unsigned f_pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned      SAT_LIMIT = f_pow10(DIGITS) - 1;
    localparam logic [BIN_WIDTH-1:0] SAT_BIN   = BIN_WIDTH'(SAT_LIMIT);

`ifdef STATUS_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0][6:0] RST_FIELD = {{(DIGITS-1){7'h20}}, 7'h30};
`else
    localparam logic [DIGITS-1:0][6:0] RST_FIELD = {DIGITS{7'h30}};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_COMMIT
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [2:0][BIN_WIDTH-1:0]       r_snap;
    logic [BIN_WIDTH-1:0]            r_bin;
    logic [BCD_W-1:0]                r_bcd;
    logic [SC_W-1:0]                 r_sc;
    logic [1:0]                      r_f;
    logic [2:0][DIGITS-1:0][6:0]     r_stage;
    logic [2:0][DIGITS-1:0][6:0]     r_digits;
    logic                            r_done;

    logic [BIN_WIDTH-1:0]            w_cur_snap;
    logic [BIN_WIDTH-1:0]            w_load_bin;
    logic [BCD_W-1:0]                w_bcd_adj;
    logic [DIGITS-1:0][6:0]          w_store_field;

    assign w_cur_snap = r_snap[r_f];
    assign w_load_bin = (64'(w_cur_snap) > SAT_LIMIT) ? SAT_BIN : w_cur_snap;

`ifdef STATUS_ZERO_BLANK_EN
    // w_zero_above[d]: nibbles d..DIGITS-1 are all zero
    logic [DIGITS:0] w_zero_above;
    assign w_zero_above[DIGITS] = 1'b1;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] w_nib;
        assign w_nib = r_bcd[4*g +: 4];
        assign w_bcd_adj[4*g +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
`ifdef STATUS_ZERO_BLANK_EN
        assign w_zero_above[g]  = w_zero_above[g+1] & (w_nib == 4'd0);
        assign w_store_field[g] = ((g != 0) && w_zero_above[g]) ? 7'h20 : {3'b011, w_nib};
`else
        assign w_store_field[g] = {3'b011, w_nib};
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_start_i) w_next = S_LOAD;
            S_LOAD:   w_next = S_SHIFT;
            S_SHIFT:  if (r_sc == SC_W'(BIN_WIDTH - 1)) w_next = S_STORE;
            S_STORE:  w_next = (r_f == 2'd2) ? S_COMMIT : S_LOAD;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_snap   <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_sc     <= '0;
            r_f      <= '0;
            r_stage  <= {3{RST_FIELD}};
            r_digits <= {3{RST_FIELD}};
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start_i) begin
                        r_snap <= {level_bin_i, lines_bin_i, score_bin_i};
                        r_f    <= '0;
                    end
                end
                S_LOAD: begin
                    r_bin <= w_load_bin;
                    r_bcd <= '0;
                    r_sc  <= '0;
                end
                S_SHIFT: begin
                    // add-3 correction then shift {bcd, bin} left by one
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
                    r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
                    r_sc  <= r_sc + 1'b1;
                end
                S_STORE: begin
                    r_stage[r_f] <= w_store_field;
                    if (r_f != 2'd2) r_f <= r_f + 2'd1;
                end
                S_COMMIT: begin
                    r_digits <= r_stage;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign digits_o      = r_digits;
    assign busy_o        = (r_state != S_IDLE);
    assign update_done_o = r_done;

endmodule

// File: tb/tb_status_digit_scheduler.sv
// Self-checking bench for status_digit_scheduler: directed timing/boundary steps plus 1000 random frames
// against an arithmetic decimal-conversion model.
module tb_status_digit_scheduler;

    localparam int unsigned LAT = 67;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    fs;
    logic [19:0]             score, lines, level;
    logic [2:0][5:0][6:0]    digits;
    logic                    busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    status_digit_scheduler #(.BIN_WIDTH(20), .DIGITS(6)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .frame_start_i (fs),
        .score_bin_i   (score),
        .lines_bin_i   (lines),
        .level_bin_i   (level),
        .digits_o      (digits),
        .busy_o        (busy),
        .update_done_o (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal rendering of a value: saturate, take each base-10 digit, optionally blank leading zeros
    function automatic logic [5:0][6:0] model_field(input int unsigned val);
        logic [5:0][6:0] r;
        int unsigned v, p, dig;
        v = (val > 999999) ? 999999 : val;
        p = 1;
        for (int d = 0; d < 6; d++) begin
            dig  = (v / p) % 10;
            r[d] = 7'(8'h30 + dig);
`ifdef STATUS_ZERO_BLANK_EN
            if (d > 0 && v < p) r[d] = 7'h20;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk_fields(input string tag, input int unsigned s, input int unsigned l, input int unsigned v);
        chk({tag, "_score"}, 64'(digits[0]), 64'(model_field(s)));
        chk({tag, "_lines"}, 64'(digits[1]), 64'(model_field(l)));
        chk({tag, "_level"}, 64'(digits[2]), 64'(model_field(v)));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_fields(tag, 0, 0, 0);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
    endtask

    // One triggered conversion with per-cycle observation of busy/done/digit stability
    task automatic convert(input string tag, input int unsigned s, input int unsigned l, input int unsigned v,
                           input bit extra_pulse, input bit change_score, input int unsigned new_score);
        logic [2:0][5:0][6:0] prev;
        int busy_cycles, done_cnt, done_at;
        bit stable;
        score = 20'(s); lines = 20'(l); level = 20'(v);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        prev = digits;
        busy_cycles = 0; done_cnt = 0; done_at = -1; stable = 1'b1;
        for (int c = 0; c < 72; c++) begin
            if (busy) busy_cycles++;
            if (done) begin done_cnt++; done_at = c; end
            if (c < int'(LAT) && digits !== prev) stable = 1'b0;
            if (c == 4 && change_score) score = 20'(new_score);
            if (c == 9 && extra_pulse) fs = 1'b1;
            if (c == 10) fs = 1'b0;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(LAT));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
        chk({tag, "_done_at"}, 64'(done_at), 64'(LAT));
        chk({tag, "_stable"}, 64'(stable), 64'(1));
        chk_fields(tag, s, l, v);
    endtask

    function automatic int unsigned rand_val();
        int unsigned edges [8] = '{0, 9, 10, 99999, 100000, 999999, 1000000, 1048575};
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 99);
            1:       return $urandom_range(0, 999999);
            2:       return $urandom_range(0, 1048575);
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    initial begin
        int unsigned s, l, v;
        int cnt;
        bit got, no_done;

        rst_n = 1'b0; fs = 1'b0; score = '0; lines = '0; level = '0;
        repeat (3) tick();
        chk_reset_state("reset");
        rst_n = 1'b1;
        tick();

        convert("basic", 12345, 7, 3, 1'b0, 1'b0, 0);
        convert("saturate", 1048575, 999999, 1000000, 1'b0, 1'b0, 0);
        convert("ignore", 100, 0, 42, 1'b1, 1'b1, 200);
        convert("blank", 5, 0, 10, 1'b0, 1'b0, 0);

        // Reset asserted mid-conversion at k+30
        score = 20'd54321; lines = 20'd88; level = 20'd9;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (29) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        no_done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done || busy) no_done = 1'b0;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done || busy) no_done = 1'b0;
        end
        chk("midreset_quiet", 64'(no_done), 64'(1));
        convert("after_reset", 54321, 88, 9, 1'b0, 1'b0, 0);

        // Back-to-back random frames; inputs scrambled while converting
        for (int n = 0; n < 1000; n++) begin
            s = rand_val(); l = rand_val(); v = rand_val();
            score = 20'(s); lines = 20'(l); level = 20'(v);
            fs = 1'b1;
            tick();
            fs = 1'b0;
            cnt = 0; got = 1'b0;
            while (!got && cnt < 80) begin
                score = 20'($urandom); lines = 20'($urandom); level = 20'($urandom);
                tick();
                cnt++;
                if (done) got = 1'b1;
            end
            chk("rand_latency", 64'(cnt), 64'(LAT));
            chk_fields("rand", s, l, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
